adder_mc: RTL and testbench
===========================

# adder_mc

Multicycle, parametrised add/subtract unit that processes WIDTH-bit operands CHUNK bits per cycle through one internal carry-lookahead chunk adder, carrying between chunks in a register. It sits in the arithmetic datapath behind a valid/ready input port and ahead of a valid/ready result port. It replaces fixed 4-bit single-cycle addition with any width, subtraction, signed-overflow reporting and backpressure.

## Interface
- WIDTH, 16, operand width; must be a multiple of CHUNK (elaboration error otherwise)
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK cycles per operation
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands/mode presented
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- sub  input  1  0: A+B, 1: A−B
- out_valid  output  1  result/ovf valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH+1  {carry_or_borrow, sum[WIDTH-1:0]}
- ovf  output  1  signed (two's complement) overflow of the operation

## Operation
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready, latch a, b (b inverted when sub=1), sub; carry register := sub; chunk index := 0; go RUN.
- RUN: each cycle, chunk i = index adds A[i*CHUNK +: CHUNK] + B'[i*CHUNK +: CHUNK] + carry using generate/propagate lookahead; write sum bits to result register, carry register := chunk carry-out; index++. After chunk N−1 go DONE.
- Final flags: result[WIDTH] = cout for add, ~cout (borrow, A<B unsigned) for sub; ovf = carry into MSB XOR cout.
- DONE: result, ovf held stable; on out_ready go IDLE.
- Operands latched at accept; changes to a/b/sub afterwards have no effect. in_valid while in_ready=0 ignored (no queueing).
- Index counter width max(1, clog2(N)). N=1 (CHUNK=WIDTH) valid: one RUN cycle.

## Timing
- Reset (async assert, any state): state IDLE, in_ready=1 after reset release, out_valid=0, result=0, ovf=0, carry/index=0; in-flight operation discarded, no result produced.
- Accept at edge T0 -> out_valid first high after edge T0+N (latency N cycles).
- Result handshake edge T0+N+1 earliest -> IDLE; next accept earliest at edge T0+N+2. Peak throughput one op per N+2 cycles.
- No combinational path input-to-output: in_ready, out_valid, result, ovf all register/state driven.
- out_ready low holds DONE indefinitely; result/ovf must not change.

## Configuration
- ADDER_MC_SAT_EN defined: on entry to DONE, result[WIDTH-1:0] clamped as unsigned saturation — add with carry-out -> all ones; sub with borrow -> zero. result[WIDTH] and ovf still report the raw carry/borrow and signed overflow.
- Undefined: result[WIDTH-1:0] is the wrapped modulo-2^WIDTH sum/difference; no clamp logic built.

## Test plan
- WIDTH=16, CHUNK=4, add 0xFFFF+0x0001 -> out_valid 4 cycles after accept, result 0x1_0000, ovf=0 (with SAT_EN: 0x1_FFFF).
- Add 0x7FFF+0x0001 -> result 0x0_8000, ovf=1; add 0x1234+0x4321 -> 0x0_5555, ovf=0.
- Sub 0x0003−0x0005 -> result 0x1_FFFE, ovf=0 (SAT_EN: 0x1_0000); sub 0x8000−0x0001 -> 0x0_7FFF, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE, toggle in_valid/a/b -> result unchanged, in_ready=0, no accept; release -> in_ready=1 next cycle.
- Assert rst_n=0 mid-RUN (after 2 chunks) -> out_valid, result, ovf = 0 immediately; after release no out_valid until a new accept.
- CHUNK=16, WIDTH=16: 0xFFFF+0xFFFF -> result 0x1_FFFE, latency 1 cycle; WIDTH=12, CHUNK=3 random A/B/sub vs. reference model, 1000 ops with random backpressure.

Source files
------------

// File: rtl/adder_mc.sv
// adder_mc: multicycle WIDTH-bit add/subtract, CHUNK bits per cycle through one lookahead chunk adder.
// Optional feature: define ADDER_MC_SAT_EN to clamp result[WIDTH-1:0] to unsigned saturation in DONE.
module adder_mc #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("adder_mc: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub, carry, last, cc, pp;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca, cb, g, p, sum;
  logic [CHUNK:0]   c;
  logic [WIDTH:0]   res;
  logic             ovf_q;

  assign ca        = op_a[idx*CHUNK +: CHUNK];
  assign cb        = op_b[idx*CHUNK +: CHUNK];
  assign g         = ca & cb;
  assign p         = ca ^ cb;
  assign sum       = p ^ c[CHUNK-1:0];
  assign last      = idx == IW'(N - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign result    = res;
  assign ovf       = ovf_q;

  // Lookahead carries: each carry is the OR of every generate passed through the propagates above it, plus carry-in
  always_comb begin
    c    = '0;
    cc   = 1'b0;
    pp   = 1'b0;
    c[0] = carry;
    for (int k = 0; k < CHUNK; k++) begin
      cc = g[k];
      pp = p[k];
      for (int j = k - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[k+1] = cc | (pp & carry);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Next state: accept in IDLE, leave RUN after the last chunk, release DONE on the result handshake
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end

  // Datapath: latch operands on accept, then fold in one chunk per RUN cycle; flags settle with the last chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      res    <= '0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      op_a   <= a;
      op_b   <= sub ? ~b : b;
      op_sub <= sub;
      carry  <= sub;
      idx    <= '0;
    end else if (state == RUN) begin
      res[idx*CHUNK +: CHUNK] <= sum;
      carry <= c[CHUNK];
      idx   <= idx + 1'b1;
      if (last) begin
        res[WIDTH] <= op_sub ^ c[CHUNK];
        ovf_q      <= c[CHUNK-1] ^ c[CHUNK];
`ifdef ADDER_MC_SAT_EN
        if (op_sub ^ c[CHUNK]) res[WIDTH-1:0] <= op_sub ? '0 : '1;
`else
`endif
      end
    end
  end
endmodule

// File: tb/tb_adder_mc.sv
// tb_adder_mc: randomized and directed checks of three adder_mc configurations against an arithmetic model.
module tb_adder_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] iv = '0, ordy = '0, sb = '0;
  logic [2:0][15:0] aa = '0, bb = '0;
  wire  [2:0] ir, ov, of;
  wire  [2:0][16:0] rr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_mc #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(aa[0]), .b(bb[0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(rr[0]), .ovf(of[0]));
  adder_mc #(.WIDTH(16), .CHUNK(16)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(aa[1]), .b(bb[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(rr[1]), .ovf(of[1]));
  adder_mc #(.WIDTH(12), .CHUNK(3)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(aa[2][11:0]), .b(bb[2][11:0]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .result(rr[2][12:0]), .ovf(of[2]));
  assign rr[2][16:13] = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y, input bit s,
                                output logic [63:0] r, output bit o);
    longint m, ux, uy, sx, sy, sr;
    bit f;
    m  = (longint'(1) << w) - 1;
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    sx = ((ux >> (w - 1)) != 0) ? ux - (m + 1) : ux;
    sy = ((uy >> (w - 1)) != 0) ? uy - (m + 1) : uy;
    sr = s ? sx - sy : sx + sy;
    o  = (sr < -((m + 1) / 2)) || (sr > (m + 1) / 2 - 1);
    f  = s ? (ux < uy) : (((ux + uy) >> w) != 0);
    r  = s ? ((ux - uy) & m) : ((ux + uy) & m);
`ifdef ADDER_MC_SAT_EN
    if (f) r = s ? 0 : m;
`else
`endif
    r = r | (64'(f) << w);
  endfunction

  task automatic op(input int i, input logic [63:0] x, input logic [63:0] y, input bit s, input int hold);
    int w, n, cnt;
    logic [63:0] er;
    bit eo;
    w = (i == 2) ? 12 : 16;
    n = (i == 1) ? 1 : 4;
    model(w, x, y, s, er, eo);
    @(negedge clk);
    iv[i] = 1'b1;
    aa[i] = 16'(x);
    bb[i] = 16'(y);
    sb[i] = s;
    cnt = 0;
    while (!ir[i] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_ready", 64'(ir[i]), 1);
    @(posedge clk);
    @(negedge clk);
    iv[i] = 1'b0;
    aa[i] = 16'($urandom);
    bb[i] = 16'($urandom);
    sb[i] = 1'($urandom);
    cnt = 0;
    while (!ov[i] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(n));
    chk("result", 64'(rr[i]), er);
    chk("ovf", 64'(of[i]), 64'(eo));
    repeat (hold) begin
      iv[i] = 1'($urandom);
      aa[i] = 16'($urandom);
      bb[i] = 16'($urandom);
      sb[i] = 1'($urandom);
      @(negedge clk);
      chk("hold_result", 64'(rr[i]), er);
      chk("hold_ovf", 64'(of[i]), 64'(eo));
      chk("hold_in_ready", 64'(ir[i]), 0);
      chk("hold_out_valid", 64'(ov[i]), 1);
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
    chk("release_in_ready", 64'(ir[i]), 1);
    chk("release_out_valid", 64'(ov[i]), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", 64'(ov[i]), 0);
      chk("reset_result", 64'(rr[i]), 0);
      chk("reset_ovf", 64'(of[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_in_ready", 64'(ir[i]), 1);

    op(0, 64'hFFFF, 64'h0001, 1'b0, 0);
`ifdef ADDER_MC_SAT_EN
    chk("lit_ffff_plus_1", 64'(rr[0]), 64'h1FFFF);
`else
    chk("lit_ffff_plus_1", 64'(rr[0]), 64'h10000);
`endif
    op(0, 64'h7FFF, 64'h0001, 1'b0, 1);
    chk("lit_7fff_ovf", 64'(of[0]), 1);
    op(0, 64'h1234, 64'h4321, 1'b0, 0);
    op(0, 64'h0003, 64'h0005, 1'b1, 2);
    op(0, 64'h8000, 64'h0001, 1'b1, 5);
    chk("lit_8000_minus_1_ovf", 64'(of[0]), 1);
    op(1, 64'hFFFF, 64'hFFFF, 1'b0, 1);
`ifdef ADDER_MC_SAT_EN
    chk("lit_n1_ffff_ffff", 64'(rr[1]), 64'h1FFFF);
`else
    chk("lit_n1_ffff_ffff", 64'(rr[1]), 64'h1FFFE);
`endif

    // Reset in the middle of RUN, two chunks into an operation
    @(negedge clk);
    iv[0] = 1'b1;
    aa[0] = 16'h1234;
    bb[0] = 16'h4321;
    sb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", 64'(ov[0]), 0);
    chk("midrun_result", 64'(rr[0]), 0);
    chk("midrun_ovf", 64'(of[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_out_valid", 64'(ov[0]), 0);
    end
    chk("post_reset_in_ready", 64'(ir[0]), 1);

    for (int k = 0; k < 40; k++) op(0, 64'($urandom), 64'($urandom), 1'($urandom), $urandom_range(0, 3));
    for (int k = 0; k < 20; k++) op(1, 64'($urandom), 64'($urandom), 1'($urandom), $urandom_range(0, 2));
    for (int k = 0; k < 1000; k++) op(2, 64'($urandom), 64'($urandom), 1'($urandom), $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
